sc_fir_decim: RTL and testbench
===============================

SC_FIR_DECIM -- requirements
Module: sc_fir_decim

Interface
REQ-001 SHALL have parameter N, default 8: stochastic bitstream resolution; one evaluation period is 2^N cycles; sample width is N+1.
REQ-002 SHALL have parameter TAPS, default 4: FIR taps per channel; power of 2, 2..16.
REQ-003 SHALL have parameter CH, default 2: independent channels sharing one RNG, sequencer and coefficient set.
REQ-004 SHALL have port clock  in  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  in  1  in_data holds a valid sample set.
REQ-007 SHALL have port in_ready  out  1  block accepts a sample set this cycle.
REQ-008 SHALL have port in_data  in  CH*(N+1)  per-channel unipolar samples; channel k in bits [k*(N+1)+N : k*(N+1)]; value v, 0..2^N, means v/2^N.
REQ-009 SHALL have port coef  in  TAPS*(N+1)  unipolar coefficients, same packing by tap index; held stable while busy.
REQ-010 SHALL have port dec_sel  in  2  decimation factor D = 1, 2, 4, 8 for codes 0..3.
REQ-011 SHALL have port out_valid  out  1  out_data holds a valid result.
REQ-012 SHALL have port out_ready  in  1  downstream accepts the result.
REQ-013 SHALL have port out_data  out  CH*(N+1)  per-channel ones-count, 0..2^N, same packing as in_data.
REQ-014 SHALL have port busy  out  1  high in RUN and HOLD.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, RUN, HOLD; in_ready = (state == IDLE).
REQ-016 Accept (in_valid && in_ready) SHALL shift each channel's sample into tap 0 of its TAPS-deep delay line, tap i moving to tap i+1 and the oldest tap dropped.
REQ-017 A 3-bit phase counter SHALL increment on each accept; when phase before increment >= D-1, where D is the dec_sel decode that cycle, phase SHALL clear to 0 and FSM SHALL go IDLE->RUN; otherwise FSM SHALL stay in IDLE.
REQ-018 Lowering dec_sel while phase exceeds the new D-1 SHALL trigger on the next accept; no sample is skipped or repeated.
REQ-019 RUN SHALL last exactly 2^N cycles, indexed by an N-bit counter cnt from 0 to 2^N-1; at cnt = 2^N-1 the FSM SHALL go to HOLD.
REQ-020 Per RUN cycle: R_x = bit-reverse(cnt); R_c = cnt; sel = the low log2(TAPS) bits of R_x.
REQ-021 Per channel, input bit = (x[sel] > R_x), coefficient bit = (coef[sel] > R_c), product bit = AND of the two (mux-based scaled adder).
REQ-022 Per-channel (N+1)-bit accumulator SHALL clear on entry to RUN and add the product bit each RUN cycle; it cannot overflow, max 2^N.
REQ-023 On RUN->HOLD, out_data SHALL load the final accumulator values, including the last cycle's bit, and out_valid SHALL rise.
REQ-024 out_valid SHALL first be high 2^N+1 cycles after the triggering accept; out_data is stable while out_valid is high.
REQ-025 In HOLD, out_valid && out_ready SHALL return the FSM to IDLE next cycle with out_valid low; out_ready while not in HOLD SHALL be ignored.
REQ-026 in_valid during RUN/HOLD SHALL be ignored; no delay-line or phase change.
REQ-027 Result = approx (1/TAPS)*sum(coef_i*x_i)/2^N scaled by 2^N; with all coef = 2^N and all taps equal to X, the result SHALL be exactly X.

Reset
REQ-028 reset_n low SHALL immediately force: state IDLE, cnt 0, phase 0, delay lines 0, accumulators 0, out_data 0, out_valid 0, busy 0, in_ready 1.
REQ-029 Reset asserted mid-RUN or mid-HOLD SHALL abort the computation; no result is emitted after release.
REQ-030 First accept is allowed in the first clock edge after reset_n rises.

Verification
REQ-031 Reset: N=8, TAPS=4, CH=2, D=1, coef all 256; accept in_data ch0=ch1=256 four times -> 4th result out_data ch0=ch1=256, out_valid 257 cycles after 4th accept.
REQ-032 Zero/mixed: coef all 256; taps ch0 all 0, ch1 all 100 -> out_data ch0=0, ch1=100.
REQ-033 Decimation: dec_sel=2 (D=4), 8 accepts -> exactly 2 results, triggered by accepts 4 and 8; in_ready low during each RUN/HOLD.
REQ-034 Backpressure: hold out_ready=0 for 50 cycles in HOLD -> out_valid and out_data stable, in_ready 0; out_ready=1 -> next cycle IDLE, in_ready 1.
REQ-035 Reset mid-RUN at cnt=100 -> all outputs at reset values immediately; out_valid never rises until new accepts complete.
REQ-036 Dec change: D=8, 5 accepts, then dec_sel=0 -> 6th accept triggers RUN.

Source files
------------

// File: rtl/sc_fir_decim.sv
// Stochastic-computing FIR with decimation: each trigger runs a 2^N-cycle bitstream
// evaluation of the TAPS-deep delay lines against a shared coefficient set.
module sc_fir_decim #(
  parameter int N    = 8,
  parameter int TAPS = 4,
  parameter int CH   = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH*(N+1)-1:0]   in_data,
  input  logic [TAPS*(N+1)-1:0] coef,
  input  logic [1:0]            dec_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*(N+1)-1:0]   out_data,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int W  = N + 1;
  localparam int SW = $clog2(TAPS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  logic [1:0]         r_state;
  logic [N-1:0]       r_cnt;
  logic [2:0]         r_phase;
  logic [W-1:0]       r_x   [CH][TAPS];
  logic [W-1:0]       r_acc [CH];
  logic [CH*W-1:0]    r_out_data;
  logic               r_out_valid;

  logic               w_accept;
  logic               w_trigger;
  logic               w_last;
  logic [2:0]         w_dm1;
  logic [N-1:0]       w_rx;
  logic [SW-1:0]      w_sel;
  logic [W-1:0]       w_coef [TAPS];
  logic               w_cbit;
  logic [CH-1:0]      w_prod;

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_RUN) || (r_state == S_HOLD);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign dbg_state = r_state;

  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_trigger = w_accept && (r_phase >= w_dm1);
  assign w_last    = (r_cnt == {N{1'b1}});
  assign w_sel     = w_rx[SW-1:0];

  always_comb begin
    w_dm1 = 3'd0;
    case (dec_sel)
      2'd0: w_dm1 = 3'd0;
      2'd1: w_dm1 = 3'd1;
      2'd2: w_dm1 = 3'd3;
      2'd3: w_dm1 = 3'd7;
      default: w_dm1 = 3'd0;
    endcase
  end

  // Bit-reversed count decorrelates the sample stream from the coefficient stream.
  always_comb begin
    w_rx = '0;
    for (int i = 0; i < N; i++) w_rx[i] = r_cnt[N-1-i];
  end

  always_comb begin
    for (int t = 0; t < TAPS; t++) w_coef[t] = coef[t*W +: W];
  end

  always_comb begin
    w_cbit = (w_coef[w_sel] > {1'b0, r_cnt});
    w_prod = '0;
    for (int k = 0; k < CH; k++) w_prod[k] = w_cbit && (r_x[k][w_sel] > {1'b0, w_rx});
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_phase     <= 3'd0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_phase <= w_trigger ? 3'd0 : r_phase + 3'd1;
            if (w_trigger) begin
              r_state <= S_RUN;
              r_cnt   <= '0;
            end
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + N'(1);
          if (w_last) begin
            r_state     <= S_HOLD;
            r_out_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < CH; k++) begin
        r_acc[k] <= '0;
        for (int t = 0; t < TAPS; t++) r_x[k][t] <= '0;
      end
      r_out_data <= '0;
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (w_accept) begin
          r_x[k][0] <= in_data[k*W +: W];
          for (int t = 1; t < TAPS; t++) r_x[k][t] <= r_x[k][t-1];
        end
        if (w_trigger) begin
          r_acc[k] <= '0;
        end else if (r_state == S_RUN) begin
          r_acc[k] <= r_acc[k] + {{N{1'b0}}, w_prod[k]};
          // The final cycle's product bit is folded straight into the result.
          if (w_last) r_out_data[k*W +: W] <= r_acc[k] + {{N{1'b0}}, w_prod[k]};
        end
      end
    end
  end

endmodule

// File: tb/tb_sc_fir_decim.sv
// Bench for sc_fir_decim: reference bitstream model feeds an expected queue that is
// compared against each result as out_valid rises.
module tb_sc_fir_decim;

  localparam int N    = 8;
  localparam int TAPS = 4;
  localparam int CH   = 2;
  localparam int W    = N + 1;
  localparam int DW   = CH * W;
  localparam int CW   = TAPS * W;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] coef = '0;
  logic [1:0]    dec_sel = 2'd0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          busy;
  logic [1:0]    dbg_state;

  sc_fir_decim #(.N(N), .TAPS(TAPS), .CH(CH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef      (coef),
    .dec_sel   (dec_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int            n_checks = 0;
  int            n_errors = 0;
  int            n_results = 0;
  logic [DW-1:0] exp_q[$];
  int            m_x[CH][TAPS];
  int            m_phase = 0;
  logic          prev_ov = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack(input int c0, input int c1);
    logic [DW-1:0] r;
    r = '0;
    r[0 +: W] = c0[W-1:0];
    r[W +: W] = c1[W-1:0];
    return r;
  endfunction

  task automatic set_coef_all(input int v);
    for (int t = 0; t < TAPS; t++) coef[t*W +: W] = v[W-1:0];
  endtask

  function automatic logic [DW-1:0] model_result();
    logic [DW-1:0] r;
    int acc, rx, sel, cv;
    r = '0;
    for (int k = 0; k < CH; k++) begin
      acc = 0;
      for (int c = 0; c < (1 << N); c++) begin
        rx = 0;
        for (int b = 0; b < N; b++) if (((c >> b) & 1) == 1) rx = rx | (1 << (N - 1 - b));
        sel = rx % TAPS;
        cv = int'(coef[sel*W +: W]);
        if (cv > c && m_x[k][sel] > rx) acc++;
      end
      r[k*W +: W] = acc[W-1:0];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < CH; k++)
      for (int t = 0; t < TAPS; t++) m_x[k][t] = 0;
    m_phase = 0;
    exp_q.delete();
  endtask

  // driver: presents one sample set and updates the model on the accepting edge
  task automatic push(input logic [DW-1:0] d, output logic trig);
    int g;
    int dm1;
    g = 0;
    while (!in_ready && g < 1000) begin
      @(posedge clock); #1; g++;
    end
    check("ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clock);
    for (int k = 0; k < CH; k++) begin
      for (int t = TAPS - 1; t > 0; t--) m_x[k][t] = m_x[k][t-1];
      m_x[k][0] = int'(d[k*W +: W]);
    end
    dm1 = (1 << dec_sel) - 1;
    trig = (m_phase >= dm1);
    m_phase = trig ? 0 : m_phase + 1;
    if (trig) exp_q.push_back(model_result());
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (!(in_ready && !out_valid) && g < 1000) begin
      @(posedge clock); #1; g++;
    end
    if (g >= 1000) check("idle_timeout", 0, 1);
  endtask

  // scoreboard
  always @(negedge clock) begin
    if (reset_n && out_valid && !prev_ov) begin
      n_results++;
      if (exp_q.size() == 0) check("unexpected_result", 1, 0);
      else check("result", out_data, exp_q.pop_front());
    end
    prev_ov = out_valid;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic trig;
    int lat, r0;
    logic ok;
    logic [DW-1:0] snap;

    model_reset();
    set_coef_all(256);
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clock); #1 reset_n = 1'b1;

    // full-scale input, D=1: first accept lands on the first edge after release
    for (int i = 0; i < 4; i++) begin
      push(pack(256, 256), trig);
      if (i == 0) check("first_accept_busy", busy, 1);
    end
    lat = 1;
    while (!out_valid && lat < 400) begin
      @(posedge clock); #1; lat++;
    end
    check("latency", lat, 257);
    check("full_scale_data", out_data, pack(256, 256));
    wait_idle();

    // zero / mixed channels
    for (int i = 0; i < 4; i++) push(pack(0, 100), trig);
    while (!out_valid) begin @(posedge clock); #1; end
    check("mixed_data", out_data, pack(0, 100));
    wait_idle();

    // decimation by 4: triggers on the 4th and 8th accept only
    dec_sel = 2'd2;
    r0 = n_results;
    for (int i = 0; i < 8; i++) begin
      push(pack(20 * i, 255 - 10 * i), trig);
      check("dec_busy", busy, (i % 4 == 3));
      check("dec_in_ready", in_ready, (i % 4 != 3));
    end
    wait_idle();
    repeat (3) @(posedge clock);
    #1 check("dec_results", n_results - r0, 2);

    // backpressure in HOLD
    dec_sel = 2'd0;
    out_ready = 1'b0;
    push(pack(37, 200), trig);
    lat = 0;
    while (!out_valid && lat < 400) begin @(posedge clock); #1; lat++; end
    check("bp_reached_hold", out_valid, 1);
    snap = out_data;
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock); #1;
      if (out_data !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
    end
    check("bp_stable", ok, 1);
    check("bp_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("bp_release_ov", out_valid, 0);
    check("bp_release_ready", in_ready, 1);

    // reset at cnt=100 aborts the run
    push(pack(150, 90), trig);
    repeat (100) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_out_data", out_data, 0);
    check("abort_state", dbg_state, 0);
    model_reset();
    @(posedge clock); #1 reset_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clock); #1;
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    check("abort_no_result", ok, 1);

    // lowering D with phase past the new limit triggers on the next accept
    dec_sel = 2'd3;
    for (int i = 0; i < 5; i++) begin
      push(pack(10 + 40 * i, 200 - 30 * i), trig);
      check("dec8_idle", busy, 0);
    end
    dec_sel = 2'd0;
    push(pack(256, 5), trig);
    check("dec_change_trigger", busy, 1);
    wait_idle();

    // random coefficients, samples and decimation
    for (int i = 0; i < 14; i++) begin
      wait_idle();
      for (int t = 0; t < TAPS; t++) coef[t*W +: W] = W'($urandom_range(0, 256));
      dec_sel = 2'($urandom_range(0, 3));
      push(pack($urandom_range(0, 256), $urandom_range(0, 256)), trig);
    end
    dec_sel = 2'd0;
    push(pack(128, 64), trig);
    wait_idle();
    repeat (5) @(posedge clock);
    #1 check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
